// File: rtl/spm_boot_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into SPM words, then enables the CPU.
// Latency: one WRITE cycle per 4 payload bytes; cpu_en rises the cycle the checksum byte is accepted.
// Backpressure: rx_ready is high only in LEN0/LEN1/DATA/CSUM; a byte offered during WRITE waits one cycle.
module spm_boot_loader #(
    parameter logic [29:0] BASE_ADDR = 30'd0,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        restart,
    output logic [29:0] test_spm_addr,
    output logic        test_spm_as_,
    output logic        test_spm_rw,
    output logic [31:0] test_spm_wr_data,
    output logic        cpu_en,
    output logic        load_err
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q;
    logic [15:0] index_q;
    logic [7:0]  xor_q;
    logic [31:0] word_q;
    logic [1:0]  byte_q;
    logic        cpu_en_q;

    logic        xfer;
    logic        clear;
    logic [15:0] len_word;
    logic [15:0] index_nxt;

    assign xfer      = rx_valid && rx_ready;
    assign len_word  = {rx_data, count_q[7:0]};
    assign index_nxt = index_q + 16'd1;
    assign clear     = restart && ((state_q == DONE) || (state_q == ERR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        rx_ready         = 1'b0;
        test_spm_as_     = 1'b1;
        test_spm_rw      = 1'b0;
        test_spm_addr    = 30'd0;
        test_spm_wr_data = 32'd0;
        case (state_q)
            IDLE: state_d = LEN0;
            LEN0: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = LEN1;
            end
            LEN1: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if ({16'd0, len_word} > MAX_W) state_d = ERR;
                    else if (len_word == 16'd0)    state_d = CSUM;
                    else                           state_d = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && (byte_q == 2'd3)) state_d = WRITE;
            end
            WRITE: begin
                test_spm_as_     = 1'b0;
                test_spm_rw      = 1'b1;
                test_spm_addr    = BASE_ADDR + {14'd0, index_q};
                test_spm_wr_data = word_q;
                state_d          = (index_nxt == count_q) ? CSUM : DATA;
            end
            CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_d = (rx_data == xor_q) ? DONE : ERR;
            end
            DONE: if (restart) state_d = IDLE;
            ERR:  if (restart) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bytes are shifted in from the top so byte k lands at [8k+7:8k] after four transfers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= 16'd0;
            index_q  <= 16'd0;
            xor_q    <= 8'd0;
            word_q   <= 32'd0;
            byte_q   <= 2'd0;
            cpu_en_q <= 1'b0;
        end else begin
            cpu_en_q <= (state_d == DONE);
            if (clear) begin
                count_q <= 16'd0;
                index_q <= 16'd0;
                xor_q   <= 8'd0;
                word_q  <= 32'd0;
                byte_q  <= 2'd0;
            end else begin
                case (state_q)
                    LEN0: if (xfer) count_q <= {8'd0, rx_data};
                    LEN1: if (xfer) count_q <= len_word;
                    DATA: begin
                        if (xfer) begin
                            word_q <= {rx_data, word_q[31:8]};
                            byte_q <= byte_q + 2'd1;
                            xor_q  <= xor_q ^ rx_data;
                        end
                    end
                    WRITE: index_q <= index_nxt;
                    default: ;
                endcase
            end
        end
    end

    assign cpu_en   = cpu_en_q;
    assign load_err = (state_q == ERR);

endmodule

// File: tb/tb_spm_boot_loader.sv
// Scoreboarded bench for spm_boot_loader: expected SPM writes are queued as bytes are driven
// and popped when the write strobe appears.
module tb_spm_boot_loader;

    localparam logic [29:0] BASE = 30'd0;
    localparam int          MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        restart;
    logic [29:0] test_spm_addr;
    logic        test_spm_as_;
    logic        test_spm_rw;
    logic [31:0] test_spm_wr_data;
    logic        cpu_en;
    logic        load_err;

    always #5 clk = ~clk;

    spm_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .restart          (restart),
        .test_spm_addr    (test_spm_addr),
        .test_spm_as_     (test_spm_as_),
        .test_spm_rw      (test_spm_rw),
        .test_spm_wr_data (test_spm_wr_data),
        .cpu_en           (cpu_en),
        .load_err         (load_err)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          strobes     = 0;
    logic [61:0] exp_q[$];
    logic [31:0] img_words[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!test_spm_as_) begin
            logic [61:0] e;
            strobes++;
            check("spm_rw", 64'(test_spm_rw), 64'd1);
            check("spm_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("spm_addr", 64'(test_spm_addr), 64'(e[61:32]));
                check("spm_data", 64'(test_spm_wr_data), 64'(e[31:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output int waited);
        waited   = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && waited < 64) begin
            waited++;
            @(negedge clk);
        end
        if (!rx_ready) begin
            check("rx_timeout", 64'(waited), 64'd0);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic gap(input bit throttle);
        if (throttle) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives LEN, payload from img_words and CSUM (xor'd with csum_flip); stop_after >= 0 abandons mid-payload.
    task automatic send_image(input logic [15:0] n, input logic [7:0] csum_flip,
                              input bit throttle, input int stop_after);
        int          w;
        logic [7:0]  x;
        logic [31:0] word;
        x = 8'd0;
        send_byte(n[7:0], w);
        gap(throttle);
        send_byte(n[15:8], w);
        gap(throttle);
        for (int k = 0; k < 4 * int'(n); k++) begin
            if (k == stop_after) return;
            word = img_words[k / 4];
            if (k % 4 == 3) exp_q.push_back({BASE + 30'(k / 4), word});
            x ^= word[8 * (k % 4) +: 8];
            send_byte(word[8 * (k % 4) +: 8], w);
            if (k % 4 == 0 && k > 0) check("held_byte_wait", 64'(w), 64'd1);
            if (k % 4 != 3) gap(throttle);
        end
        send_byte(x ^ csum_flip, w);
        if (n != 16'd0) check("held_csum_wait", 64'(w), 64'd1);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        check("restart_cpu_en_drop", 64'(cpu_en), 64'd0);
        @(posedge clk);
        #1;
        check("restart_rx_ready", 64'(rx_ready), 64'd1);
        check("restart_load_err", 64'(load_err), 64'd0);
    endtask

    task automatic check_end(input string tag, input bit ok, input int s0, input int nwr);
        check({tag, "_cpu_en"}, 64'(cpu_en), 64'(ok));
        check({tag, "_load_err"}, 64'(load_err), 64'(!ok));
        check({tag, "_strobes"}, 64'(strobes - s0), 64'(nwr));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int w;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        restart  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_as", 64'(test_spm_as_), 64'd1);
        check("rst_rw", 64'(test_spm_rw), 64'd0);
        check("rst_addr", 64'(test_spm_addr), 64'd0);
        check("rst_wdata", 64'(test_spm_wr_data), 64'd0);
        check("rst_cpu_en", 64'(cpu_en), 64'd0);
        check("rst_load_err", 64'(load_err), 64'd0);
        reset = 1'b1;

        // Nominal two-word image, back-to-back.
        img_words = '{32'h0000_0013, 32'h0010_0093};
        s0 = strobes;
        send_image(16'd2, 8'h00, 1'b0, -1);
        check_end("nominal", 1'b1, s0, 2);
        do_restart();

        // Bad checksum: writes still happen, then ERR is held until restart.
        s0 = strobes;
        send_image(16'd2, 8'h01, 1'b0, -1);
        check_end("badcsum", 1'b0, s0, 2);
        repeat (3) @(posedge clk);
        #1;
        check("badcsum_err_held", 64'(load_err), 64'd1);
        check("badcsum_cpu_en_held", 64'(cpu_en), 64'd0);
        do_restart();

        // Zero length.
        s0 = strobes;
        send_image(16'd0, 8'h00, 1'b0, -1);
        check_end("zerolen", 1'b1, s0, 0);
        do_restart();

        // Over-length: N = MAXW + 1.
        s0 = strobes;
        send_byte(8'd5, w);
        send_byte(8'd0, w);
        check("overlen_err", 64'(load_err), 64'd1);
        check("overlen_rx_ready", 64'(rx_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("overlen_strobes", 64'(strobes - s0), 64'd0);
        check("overlen_cpu_en", 64'(cpu_en), 64'd0);
        do_restart();

        // Boundary: N == MAXW with random payload.
        img_words.delete();
        for (int i = 0; i < MAXW; i++) img_words.push_back($urandom());
        s0 = strobes;
        send_image(16'(MAXW), 8'h00, 1'b0, -1);
        check_end("maxlen", 1'b1, s0, MAXW);
        do_restart();

        // Throttled nominal image.
        img_words = '{32'h0000_0013, 32'h0010_0093};
        s0 = strobes;
        send_image(16'd2, 8'h00, 1'b1, -1);
        check_end("throttle", 1'b1, s0, 2);
        do_restart();

        // Reset after the 6th payload byte, then a full reload from word 0.
        s0 = strobes;
        send_image(16'd2, 8'h00, 1'b0, 6);
        check("midrst_strobes", 64'(strobes - s0), 64'd1);
        reset = 1'b0;
        #1;
        check("midrst_rx_ready", 64'(rx_ready), 64'd0);
        check("midrst_as", 64'(test_spm_as_), 64'd1);
        check("midrst_addr", 64'(test_spm_addr), 64'd0);
        check("midrst_cpu_en", 64'(cpu_en), 64'd0);
        check("midrst_load_err", 64'(load_err), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        s0 = strobes;
        send_image(16'd2, 8'h00, 1'b0, -1);
        check_end("reload", 1'b1, s0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spm_boot_loader.md
SPM_BOOT_LOADER -- requirements
Module: spm_boot_loader

Interface
REQ-001 Parameter BASE_ADDR, default 30'd0, is the SPM word address that receives payload word 0.
REQ-002 Parameter MAX_WORDS, default 1024, is the largest accepted word count.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  incoming image byte.
REQ-006 rx_valid  input  1  rx_data is valid this cycle.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready are high at a rising edge.
REQ-008 restart  input  1  single-cycle request to begin a new load.
REQ-009 test_spm_addr  output  30  SPM word address.
REQ-010 test_spm_as_  output  1  active-low SPM access strobe.
REQ-011 test_spm_rw  output  1  SPM direction, 1 = write.
REQ-012 test_spm_wr_data  output  32  SPM write word.
REQ-013 cpu_en  output  1  CPU run enable; high only after a verified load.
REQ-014 load_err  output  1  sticky error flag for the current load.

Function
REQ-015 Image format: LEN_LO, LEN_HI (16-bit word count N), then 4*N payload bytes with each word little-endian, then CSUM, where CSUM is the XOR of all payload bytes.
REQ-016 The FSM SHALL use states IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE and ERR.
REQ-017 IDLE SHALL go to LEN0 in the cycle after reset release, and on restart from DONE or ERR.
REQ-018 LEN0 and LEN1 SHALL each accept one byte into the count register.
REQ-019 After LEN1: N > MAX_WORDS goes to ERR; N == 0 goes to CSUM; otherwise the FSM goes to DATA.
REQ-020 DATA SHALL accept 4 bytes into the word shift register, with byte k placed at bits [8k+7:8k], and SHALL fold each byte into the running XOR.
REQ-021 After the 4th byte the FSM SHALL enter WRITE for exactly one cycle.
REQ-022 In WRITE the outputs SHALL be: test_spm_as_=0, test_spm_rw=1, test_spm_addr=BASE_ADDR+index, test_spm_wr_data=assembled word.
REQ-023 After WRITE the word index SHALL increment; the FSM goes to CSUM when index==N, else back to DATA.
REQ-024 rx_ready SHALL be 1 only in LEN0, LEN1, DATA and CSUM, and 0 in all other states, including WRITE.
REQ-025 Outside WRITE the SPM outputs SHALL be: test_spm_as_=1, test_spm_rw=0, test_spm_addr=0, test_spm_wr_data=0.
REQ-026 In CSUM the received byte SHALL be compared with the running XOR: equal goes to DONE, unequal goes to ERR.
REQ-027 cpu_en SHALL be registered and rise in the first cycle in DONE; it SHALL be 0 in every other state.
REQ-028 load_err SHALL be 1 in ERR and 0 otherwise; ERR is held until restart.
REQ-029 restart SHALL be ignored while in LEN0 through CSUM; a load in progress is not aborted.
REQ-030 On restart, the count, index, XOR and shift registers SHALL clear, and cpu_en SHALL drop the next cycle.
REQ-031 Address arithmetic SHALL be 30-bit and wrap modulo 2^30.
REQ-032 The index SHALL be 16-bit.
REQ-033 rx_valid low in any state SHALL cause no state change; there is no timeout.

Reset
REQ-034 On reset low, the FSM SHALL go to IDLE immediately (asynchronously).
REQ-035 During reset, outputs SHALL be: rx_ready=0, test_spm_as_=1, test_spm_rw=0, test_spm_addr=0, test_spm_wr_data=0, cpu_en=0, load_err=0.
REQ-036 During reset, all counters and the XOR accumulator SHALL be 0.
REQ-037 Reset asserted mid-load SHALL abandon the load; SPM words already written are not reverted.

Verification
REQ-038 Nominal load: bytes 02 00 | 13 00 00 00 | 93 00 10 00 | CSUM=0x90 with back-to-back valid -> exactly two write strobes: addr 0 data 0x00000013, then addr 1 data 0x00100093; cpu_en=1; load_err=0.
REQ-039 Bad checksum: same image with CSUM=0x91 -> both SPM writes occur; load_err=1; cpu_en stays 0; after a restart pulse, the FSM is in LEN0 with load_err=0.
REQ-040 Zero length: bytes 00 00 00 -> no SPM strobe; cpu_en=1 after CSUM.
REQ-041 Over-length: MAX_WORDS=4 with N=5 (bytes 05 00) -> ERR right after LEN1; no SPM write; rx_ready=0.
REQ-042 Throttled input: rx_valid toggled every other cycle, plus one cycle where rx_ready=0 with rx_valid=1 during WRITE -> identical SPM writes to REQ-038; the held byte transfers in the following cycle.
REQ-043 Reset mid-load: reset pulsed low after the 6th payload byte of REQ-038 -> outputs go to reset values at once; a fresh full image then loads correctly from word 0.
